binary_line_buffer: RTL and testbench

BINARY_LINE_BUFFER -- requirements
Module: binary_line_buffer

---
 rtl/binary_line_buffer.sv | 127 ++++++++++++
 tb/tb_binary_line_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/binary_line_buffer.sv
// Two-line binary line buffer producing a 3-pixel vertical column per accepted beat.
// Optional top-edge zero padding is enabled by defining LB_ZERO_PAD_EN.
module binary_line_buffer #(
  parameter int unsigned HRES = 320,
  parameter int unsigned VRES = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  output logic [2:0]  data_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out,
  output logic        lines_primed
);

  localparam int unsigned AW = (HRES > 1) ? $clog2(HRES) : 1;

  // line_a holds row v-1, line_b holds row v-2
  logic line_a [HRES];
  logic line_b [HRES];

  logic          accept_c;
  logic [AW-1:0] addr_c;

  assign accept_c = data_valid_in && (hcount_in < 11'(HRES)) && !rst_in;
  assign addr_c   = hcount_in[AW-1:0];

  // stage 1: registered store reads plus the beat's own pixel and position
  logic        s1_valid;
  logic        s1_pix;
  logic        s1_a;
  logic        s1_b;
  logic [10:0] s1_h;
  logic [9:0]  s1_v;

  // stage 2: assembled column
  logic        s2_valid;
  logic [2:0]  s2_data;
  logic [10:0] s2_h;
  logic [9:0]  s2_v;

  logic [2:0]  col_c;
  logic [9:0]  vwrap_c;

  // line stores: read-before-write shift of A into B; contents survive reset
  always_ff @(posedge clk_in) begin
    if (accept_c) begin
      s1_a           <= line_a[addr_c];
      s1_b           <= line_b[addr_c];
      line_b[addr_c] <= line_a[addr_c];
      line_a[addr_c] <= pixel_in;
    end
  end

  always_comb begin
    col_c = {s1_b, s1_a, s1_pix};
`ifdef LB_ZERO_PAD_EN
    if (s1_v == 10'd0) begin
      col_c[2:1] = 2'b00;
    end else if (s1_v == 10'd1) begin
      col_c[2] = 1'b0;
    end
`endif
    vwrap_c = (s1_v == 10'd0) ? 10'(VRES - 1) : (s1_v - 10'd1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_pix   <= 1'b0;
      s1_h     <= '0;
      s1_v     <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_h     <= '0;
      s2_v     <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_pix <= pixel_in;
        s1_h   <= hcount_in;
        s1_v   <= vcount_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= col_c;
        s2_h    <= s1_h;
        s2_v    <= vwrap_c;
      end
    end
  end

  // output register holds its payload between beats
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      data_out       <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      data_valid_out <= s2_valid;
      if (s2_valid) begin
        data_out   <= s2_data;
        hcount_out <= s2_h;
        vcount_out <= s2_v;
      end
    end
  end

  // cleared at frame start, set once a row of index >= 2 begins
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lines_primed <= 1'b0;
    end else if (accept_c) begin
      if (vcount_in == 10'd0 && hcount_in == 11'd0) begin
        lines_primed <= 1'b0;
      end else if (vcount_in >= 10'd2) begin
        lines_primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binary_line_buffer.sv
// Scoreboard bench for binary_line_buffer: driver pushes expected columns, monitor pops on data_valid_out.
module tb_binary_line_buffer;

  localparam int HRES = 320;
  localparam int VRES = 180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        valid = 1'b0;
  logic [2:0]  data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic        lines_primed;

  binary_line_buffer #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in(clk), .rst_in(rst), .pixel_in(pixel), .hcount_in(hcount),
    .vcount_in(vcount), .data_valid_in(valid), .data_out(data_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .data_valid_out(data_valid_out), .lines_primed(lines_primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  d;
    logic [2:0]  m;
    logic [10:0] h;
    logic [9:0]  v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   primed_exp = 1'b0;

  // reference line contents and whether each entry is known
  bit ref_a [HRES];
  bit ref_b [HRES];
  bit ka [HRES];
  bit kb [HRES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit p, input int h, input int v);
    exp_t e;
    @(negedge clk);
    rst    = 1'b0;
    valid  = en;
    pixel  = p;
    hcount = 11'(h);
    vcount = 10'(v);
    if (en && h < HRES) begin
      e.d = {ref_b[h], ref_a[h], p};
      e.m = {kb[h], ka[h], 1'b1};
`ifdef LB_ZERO_PAD_EN
      if (v == 0) begin
        e.d[2:1] = 2'b00;
        e.m[2:1] = 2'b11;
      end else if (v == 1) begin
        e.d[2] = 1'b0;
        e.m[2] = 1'b1;
      end
`endif
      e.h   = 11'(h);
      e.v   = (v == 0) ? 10'(VRES - 1) : 10'(v - 1);
      e.cyc = cyc + 3;
      q.push_back(e);
      ref_b[h] = ref_a[h];
      kb[h]    = ka[h];
      ref_a[h] = p;
      ka[h]    = 1'b1;
      if (v == 0 && h == 0) primed_exp = 1'b0;
      else if (v >= 2) primed_exp = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic row(input int v, input int pat);
    bit p;
    for (int h = 0; h < HRES; h++) begin
      case (pat)
        0: p = 1'b0;
        1: p = 1'b1;
        2: p = 1'(h & 1);
        default: p = 1'((h ^ v) & 1);
      endcase
      drive(1'b1, p, h, v);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0] d, input logic [10:0] h, input logic [9:0] v);
    chk({name, "_data"}, 32'(data_out), 32'(d));
    chk({name, "_hcount"}, 32'(hcount_out), 32'(h));
    chk({name, "_vcount"}, 32'(vcount_out), 32'(v));
  endtask

  // monitor: pops on every output beat, otherwise checks that outputs hold
  initial begin
    exp_t e;
    logic [2:0]  hold_d = '0;
    logic [2:0]  hold_m = 3'b111;
    logic [10:0] hold_h = '0;
    logic [9:0]  hold_v = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        hold_d = '0;
        hold_m = 3'b111;
        hold_h = '0;
        hold_v = '0;
      end
      if (data_valid_out === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(hcount_out), 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("beat_cycle", 32'(cyc), 32'(e.cyc));
          chk("beat_data", 32'(data_out & e.m), 32'(e.d & e.m));
          chk("beat_hcount", 32'(hcount_out), 32'(e.h));
          chk("beat_vcount", 32'(vcount_out), 32'(e.v));
          hold_d = e.d;
          hold_m = e.m;
          hold_h = e.h;
          hold_v = e.v;
        end
      end else begin
        chk("valid_low", 32'(data_valid_out), 32'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing_beat", 32'(cyc), 32'(q[0].cyc));
          void'(q.pop_front());
        end
        chk("hold_data", 32'(data_out & hold_m), 32'(hold_d & hold_m));
        chk("hold_hcount", 32'(hcount_out), 32'(hold_h));
        chk("hold_vcount", 32'(vcount_out), 32'(hold_v));
      end
      chk("lines_primed", 32'(lines_primed), 32'(primed_exp));
    end
  end

  initial begin
    for (int i = 0; i < HRES; i++) begin
      ref_a[i] = 1'b0; ref_b[i] = 1'b0; ka[i] = 1'b0; kb[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_out("reset", 3'b000, 11'd0, 10'd0);
    chk("reset_valid", 32'(data_valid_out), 32'd0);
    chk("reset_primed", 32'(lines_primed), 32'd0);

    // preload the stores with zeros from the tail of a previous frame
    row(178, 0);
    row(179, 0);
    idle(4);

    // rows 0..2 of all-ones
    row(0, 1);
    idle(4);
    chk_out("row0", 3'b001, 11'd319, 10'd179);
    chk("row0_primed", 32'(lines_primed), 32'd0);
    row(1, 1);
    idle(4);
    chk_out("row1", 3'b011, 11'd319, 10'd0);
    chk("row1_primed", 32'(lines_primed), 32'd0);
    row(2, 1);
    idle(4);
    chk_out("row2", 3'b111, 11'd319, 10'd1);
    chk("row2_primed", 32'(lines_primed), 32'd1);

    // out-of-range column is dropped, last column behaves normally
    drive(1'b1, 1'b1, HRES, 3);
    idle(4);
    chk_out("h320_dropped", 3'b111, 11'd319, 10'd1);
    row(3, 0);
    idle(4);
    chk_out("h319_row3", 3'b110, 11'd319, 10'd2);

    // one-cycle reset pulse in the middle of row 5
    row(4, 2);
    for (int h = 0; h < 100; h++) drive(1'b1, 1'((h + 1) & 1), h, 5);
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    q.delete();
    primed_exp = 1'b0;
    @(negedge clk);
    chk_out("mid_reset", 3'b000, 11'd0, 10'd0);
    chk("mid_reset_valid", 32'(data_valid_out), 32'd0);
    chk("mid_reset_primed", 32'(lines_primed), 32'd0);
    for (int h = 100; h < HRES; h++) drive(1'b1, 1'((h + 1) & 1), h, 5);
    idle(4);

    // checkerboard with valid 1-on 2-off
    for (int v = 6; v <= 8; v++) begin
      for (int h = 0; h < HRES; h++) begin
        drive(1'b1, 1'((h ^ v) & 1), h, v);
        drive(1'b0, 1'b0, h, v);
        drive(1'b0, 1'b0, h, v);
      end
    end
    idle(4);
    chk_out("checker", 3'b101, 11'd319, 10'd7);

    // new frame start drops lines_primed until row 2 begins
    chk("pre_frame_primed", 32'(lines_primed), 32'd1);
    drive(1'b1, 1'b1, 0, 0);
    idle(1);
    chk("frame_start_primed", 32'(lines_primed), 32'd0);
    for (int h = 1; h < 4; h++) drive(1'b1, 1'b0, h, 0);
    for (int h = 0; h < 4; h++) drive(1'b1, 1'b1, h, 1);
    idle(1);
    chk("row1_start_primed", 32'(lines_primed), 32'd0);
    drive(1'b1, 1'b0, 0, 2);
    idle(1);
    chk("row2_start_primed", 32'(lines_primed), 32'd1);
    idle(6);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
